ma_stage_hs: RTL and testbench
==============================

Name: ma_stage_hs

Overview:
Parametrised memory-access pipeline stage for the CowCat32 core. It sits between EX and WB and talks to data memory over a req/ack handshake, so memory may insert any number of wait states. It generates store byte-enables and lane-shifted store data, aligns and extends load data, and detects misaligned accesses. It stalls the upstream pipeline while an access is outstanding and registers din/inst/exception into WB.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (64 adds doubleword D and LWU).
BE_W, XLEN/8, byte-enable width (derived, not overridable).
NOP_INST, 32'h0000_0013, bubble instruction inserted into WB on stall.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
inst_ma  in  32  instruction in MA
pc_ma  in  XLEN  PC of inst_ma
alu_out  in  XLEN  ALU result / effective address
d2_ma  in  XLEN  store source (rs2)
mem_rd  in  1  inst_ma is a load
mem_wr  in  1  inst_ma is a store (mem_rd&mem_wr never both 1)
mem_size  in  2  0=B 1=H 2=W 3=D
mem_uns  in  1  zero-extend load
din_sel  in  2  0=alu_out 1=load data 2=pc_ma+4 3=reserved (drives 0)
hold  in  1  global freeze from downstream/debug
dm_req  out  1  access request
dm_we  out  1  write strobe, valid with dm_req
dm_addr  out  XLEN  naturally aligned word address (alu_out with low log2(BE_W) bits cleared)
dm_be  out  BE_W  byte enables
dm_wdata  out  XLEN  store data shifted to lane
dm_rdata  in  XLEN  read data, valid with dm_ack
dm_ack  in  1  access complete
stall_req  out  1  freeze IF..MA this cycle
din  out  XLEN  WB write data (registered)
inst_wb  out  32  WB instruction (registered)
misalign_wb  out  1  misaligned-access flag to WB (registered)
fwd_data  out  XLEN  combinational next-din for forwarding

Behaviour:
- Reset is synchronous and active-low: at any clk edge with rst=0 -> state IDLE, din=0, inst_wb=NOP_INST, misalign_wb=0. dm_req=0 from the next cycle. No partial state is retained after reset mid-access. An ack arriving in IDLE is ignored.
- mis = (H & a[0]) | (W & a[1:0]!=0) | (D & a[2:0]!=0) | (D & XLEN==32), where a=alu_out. go = (mem_rd|mem_wr) & ~mis.
- FSM:
  - IDLE: if go & ~hold -> ACCESS.
  - ACCESS: dm_req=1. addr/be/wdata/we held stable. On dm_ack: capture dm_rdata into rbuf and go to DONE. Stay in ACCESS while ack is low. hold does not abort an access.
  - DONE: if ~hold -> IDLE, else stay in DONE.
- stall_req = (IDLE & go) | ACCESS. A zero-wait access therefore costs 2 stall cycles. DONE is the advance cycle.
- Advance enable adv = ~hold & ~stall_req. On adv: din<=fwd_data, inst_wb<=inst_ma, misalign_wb<=mis&(mem_rd|mem_wr). On ~hold & stall_req: inst_wb<=NOP_INST, din<=0, misalign_wb<=0 (bubble). On hold: all WB registers keep their value.
- Misaligned access: no dm_req is issued, no stall, and it advances with misalign_wb=1. For a load with din_sel=1, din=0.
- dm_be:
  - B = 1<<off
  - H = 2'b11<<off
  - W = 4'hF<<off (off = byte offset within XLEN word)
  - D = all ones
- dm_wdata = d2_ma replicated/shifted so that each byte sits on its lane.
- Load align:
  - select bytes rbuf>>(8*off), truncate to size.
  - sign- or zero-extend per mem_uns to XLEN.
  - mem_uns ignored for D.
  - load data is taken from rbuf in DONE.
- dm_req is only ever 1 in ACCESS. dm_we=mem_wr in ACCESS, else 0.

Decomposition:
- Package ma_pkg holds the mem_size encodings, din_sel encodings, NOP_INST, the state enum {IDLE, ACCESS, DONE}, and function be_gen(size, off).
- One sub-module, load_align (params XLEN): rdata, off, size, uns -> aligned extended data. It is purely combinational and reused by future LSU work.
- FSM, store shifter, din mux and WB registers stay in ma_stage_hs.

Test Plan:
- Reset: rst=0 for 2 cycles mid-ACCESS -> dm_req=0 after the edge, inst_wb=0x00000013, din=0; next op starts cleanly from IDLE.
- LB, alu_out=0x1003, dm_rdata=0x80FF_1234, ack with 0 waits -> dm_addr=0x1000, dm_be=4'b1000, stall_req high for 2 cycles, din=0xFFFF_FF80. The LBU variant gives din=0x0000_0080.
- SH, alu_out=0x2002, d2_ma=0x0000_BEEF, ack after 3 waits -> dm_we=1, dm_be=4'b1100, dm_wdata[31:16]=0xBEEF, stall_req high 5 cycles, inst_wb gets NOPs then the SH.
- LW, alu_out=0x3001 -> no dm_req, no stall, misalign_wb=1 next cycle, din=0.
- hold=1 asserted in DONE for 2 cycles -> state remains DONE, WB registers frozen, no second dm_req; the instruction advances on hold release.
- XLEN=64 LD, alu_out=0x18, dm_rdata=0x8000_0000_0000_0001 -> dm_be=8'hFF, din=0x8000_0000_0000_0001. LWU at 0x1C of the same data -> din=0x0000_0000_8000_0000.

Source files
------------

// File: rtl/ma_pkg.sv
// Shared encodings and helpers for the MA pipeline stage.
//   mem_size codes, din_sel codes, the default bubble instruction,
//   the MA access state enum and the byte-enable generator.
package ma_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] DIN_ALU  = 2'd0;
    localparam logic [1:0] DIN_LOAD = 2'd1;
    localparam logic [1:0] DIN_PC4  = 2'd2;
    localparam logic [1:0] DIN_RSVD = 2'd3;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Byte enables for an access of the given size at byte offset off.
    // Returned at the widest lane count; callers truncate to their bus width.
    function automatic logic [7:0] be_gen(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] be;
        case (size)
            SZ_B:    be = 8'h01 << off;
            SZ_H:    be = 8'h03 << off;
            SZ_W:    be = 8'h0F << off;
            default: be = 8'hFF;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ma_stage_hs_load_align.sv
// Load data aligner: shifts the addressed bytes down to bit 0, truncates to
// the access size and sign/zero-extends to XLEN. Purely combinational.
//   rdata_i : raw memory word      off_i  : byte offset within the word
//   size_i  : access size code     uns_i  : zero-extend when set
//   data_o  : aligned, extended load value
module load_align
    import ma_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]           rdata_i,
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  logic [1:0]                size_i,
    input  logic                      uns_i,
    output logic [XLEN-1:0]           data_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        data_o  = shifted;
        case (size_i)
            SZ_B: begin
                if (uns_i) data_o = XLEN'(shifted[7:0]);
                else       data_o = XLEN'($signed(shifted[7:0]));
            end
            SZ_H: begin
                if (uns_i) data_o = XLEN'(shifted[15:0]);
                else       data_o = XLEN'($signed(shifted[15:0]));
            end
            SZ_W: begin
                if (uns_i) data_o = XLEN'(shifted[31:0]);
                else       data_o = XLEN'($signed(shifted[31:0]));
            end
            // Doubleword fills the whole datapath; extension mode is moot.
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/ma_stage_hs.sv
// CowCat32 memory-access stage with a req/ack data-memory handshake.
// Launches aligned loads/stores, stalls upstream while an access is
// outstanding, aligns load data and registers din/inst/misalign into WB.
//   clk, rst            : clock, synchronous active-low reset
//   inst_ma..din_sel    : instruction and operands from EX
//   hold                : global freeze
//   dm_*                : data-memory request/response
//   stall_req, fwd_data : combinational stall and forwarding value
//   din, inst_wb, misalign_wb : registered WB payload
module ma_stage_hs #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] NOP_INST = ma_pkg::NOP_INST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         inst_ma,
    input  logic [XLEN-1:0]     pc_ma,
    input  logic [XLEN-1:0]     alu_out,
    input  logic [XLEN-1:0]     d2_ma,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [1:0]          mem_size,
    input  logic                mem_uns,
    input  logic [1:0]          din_sel,
    input  logic                hold,
    output logic                dm_req,
    output logic                dm_we,
    output logic [XLEN-1:0]     dm_addr,
    output logic [XLEN/8-1:0]   dm_be,
    output logic [XLEN-1:0]     dm_wdata,
    input  logic [XLEN-1:0]     dm_rdata,
    input  logic                dm_ack,
    output logic                stall_req,
    output logic [XLEN-1:0]     din,
    output logic [31:0]         inst_wb,
    output logic                misalign_wb,
    output logic [XLEN-1:0]     fwd_data
);
    import ma_pkg::*;

    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    state_e           state_q;
    logic [XLEN-1:0]  rbuf_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [BE_W-1:0]  be_q;
    logic             we_q;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [XLEN-1:0]  din_q;
    logic [31:0]      inst_wb_q;
    logic             misalign_q;

    logic [OFF_W-1:0] off;
    logic             mem_op;
    logic             mis;
    logic             go;
    logic             adv;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  din_d;

    assign off    = alu_out[OFF_W-1:0];
    assign mem_op = mem_rd | mem_wr;

    // Doublewords are never legal on a 32-bit datapath.
    assign mis = ((mem_size == SZ_H) && alu_out[0])
              || ((mem_size == SZ_W) && (alu_out[1:0] != 2'b00))
              || ((mem_size == SZ_D) && ((alu_out[2:0] != 3'b000) || (XLEN == 32)));

    assign go        = mem_op & ~mis;
    assign stall_req = ((state_q == ST_IDLE) && go) || (state_q == ST_ACCESS);
    assign adv       = ~hold & ~stall_req;

    // Align from the captured access attributes so DONE does not depend on EX.
    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i (rbuf_q),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .data_o  (load_data)
    );

    // Next WB data; load data is only valid in the DONE cycle.
    always_comb begin
        din_d = '0;
        case (din_sel)
            DIN_ALU:  din_d = alu_out;
            DIN_LOAD: din_d = (state_q == ST_DONE) ? load_data : '0;
            DIN_PC4:  din_d = pc_ma + XLEN'(4);
            default:  din_d = '0;
        endcase
    end

    assign fwd_data = din_d;

    // Access FSM; request attributes are latched at launch and held for the access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rbuf_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go && !hold) begin
                        state_q <= ST_ACCESS;
                        addr_q  <= alu_out & ~XLEN'(BE_W - 1);
                        be_q    <= BE_W'(be_gen(mem_size, 3'(off)));
                        wdata_q <= d2_ma << {off, 3'b000};
                        we_q    <= mem_wr;
                        off_q   <= off;
                        size_q  <= mem_size;
                        uns_q   <= mem_uns;
                    end
                end
                ST_ACCESS: begin
                    if (dm_ack) begin
                        rbuf_q  <= dm_rdata;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!hold) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // WB registers: advance, bubble while stalling, freeze on hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            din_q      <= '0;
            inst_wb_q  <= NOP_INST;
            misalign_q <= 1'b0;
        end else if (adv) begin
            din_q      <= din_d;
            inst_wb_q  <= inst_ma;
            misalign_q <= mis & mem_op;
        end else if (!hold) begin
            din_q      <= '0;
            inst_wb_q  <= NOP_INST;
            misalign_q <= 1'b0;
        end
    end

    assign dm_req      = (state_q == ST_ACCESS);
    assign dm_we       = dm_req & we_q;
    assign dm_addr     = addr_q;
    assign dm_be       = be_q;
    assign dm_wdata    = wdata_q;
    assign din         = din_q;
    assign inst_wb     = inst_wb_q;
    assign misalign_wb = misalign_q;

endmodule

// File: tb/tb_ma_stage_hs.sv
// Scoreboard bench for ma_stage_hs: a 32-bit and a 64-bit instance share
// the stimulus; sel64 picks which one may issue memory ops and is observed.
module tb_ma_stage_hs;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, D = 2'd3;
    localparam logic [1:0] ALU = 2'd0, LOAD = 2'd1, PC4 = 2'd2, RSVD = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel64 = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] inst_ma;
    logic [63:0] pc_ma, alu_out, d2_ma, dm_rdata;
    logic        mem_rd, mem_wr, mem_uns, hold, dm_ack;
    logic [1:0]  mem_size, din_sel;

    logic        req32, we32, stall32, mis32;
    logic [31:0] addr32, wdata32, din32, fwd32, inst32;
    logic [3:0]  be32;
    logic        req64, we64, stall64, mis64;
    logic [63:0] addr64, wdata64, din64, fwd64;
    logic [31:0] inst64;
    logic [7:0]  be64;

    ma_stage_hs #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .inst_ma(inst_ma), .pc_ma(pc_ma[31:0]),
        .alu_out(alu_out[31:0]), .d2_ma(d2_ma[31:0]),
        .mem_rd(mem_rd & ~sel64), .mem_wr(mem_wr & ~sel64),
        .mem_size(mem_size), .mem_uns(mem_uns), .din_sel(din_sel), .hold(hold),
        .dm_req(req32), .dm_we(we32), .dm_addr(addr32), .dm_be(be32),
        .dm_wdata(wdata32), .dm_rdata(dm_rdata[31:0]), .dm_ack(dm_ack & ~sel64),
        .stall_req(stall32), .din(din32), .inst_wb(inst32),
        .misalign_wb(mis32), .fwd_data(fwd32)
    );

    ma_stage_hs #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .inst_ma(inst_ma), .pc_ma(pc_ma),
        .alu_out(alu_out), .d2_ma(d2_ma),
        .mem_rd(mem_rd & sel64), .mem_wr(mem_wr & sel64),
        .mem_size(mem_size), .mem_uns(mem_uns), .din_sel(din_sel), .hold(hold),
        .dm_req(req64), .dm_we(we64), .dm_addr(addr64), .dm_be(be64),
        .dm_wdata(wdata64), .dm_rdata(dm_rdata), .dm_ack(dm_ack & sel64),
        .stall_req(stall64), .din(din64), .inst_wb(inst64),
        .misalign_wb(mis64), .fwd_data(fwd64)
    );

    logic        obs_req, obs_we, obs_stall, obs_mis;
    logic [63:0] obs_addr, obs_wdata, obs_din, obs_fwd;
    logic [7:0]  obs_be;
    logic [31:0] obs_inst;

    always_comb begin
        if (sel64) begin
            obs_req = req64; obs_we = we64; obs_stall = stall64; obs_mis = mis64;
            obs_addr = addr64; obs_wdata = wdata64; obs_din = din64; obs_fwd = fwd64;
            obs_be = be64; obs_inst = inst64;
        end else begin
            obs_req = req32; obs_we = we32; obs_stall = stall32; obs_mis = mis32;
            obs_addr = {32'h0, addr32}; obs_wdata = {32'h0, wdata32};
            obs_din = {32'h0, din32}; obs_fwd = {32'h0, fwd32};
            obs_be = {4'h0, be32}; obs_inst = inst32;
        end
    end

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] din;
        logic        mis;
    } wb_t;

    wb_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every new non-bubble instruction landing in WB is checked.
    logic [31:0] prev_inst = NOP;
    always @(negedge clk) begin : mon
        wb_t e;
        if (!rst) begin
            prev_inst = NOP;
        end else if (obs_inst != prev_inst) begin
            prev_inst = obs_inst;
            if (obs_inst != NOP) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got inst %h expected none", obs_inst);
                end else begin
                    e = sbq.pop_front();
                    chk("wb_inst", 64'(obs_inst), 64'(e.inst));
                    chk("wb_din", obs_din, e.din);
                    chk("wb_mis", 64'(obs_mis), 64'(e.mis));
                end
            end
        end
    end

    task automatic set_in(input logic [31:0] inst, input logic [63:0] pc, alu, d2,
                          input logic rd, wr, input logic [1:0] size, input logic uns,
                          input logic [1:0] dsel);
        inst_ma = inst; pc_ma = pc; alu_out = alu; d2_ma = d2;
        mem_rd = rd; mem_wr = wr; mem_size = size; mem_uns = uns; din_sel = dsel;
    endtask

    // Called #1 after a posedge; returns #1 after the edge that advances the op.
    task automatic run_op(input logic [31:0] inst, input logic [63:0] pc, alu, d2,
                          input logic rd, wr, input logic [1:0] size, input logic uns,
                          input logic [1:0] dsel, input int waits, input logic [63:0] rdata,
                          input bit hold_done, input int exp_stalls, input int exp_reqs,
                          input logic [63:0] exp_addr, input logic [7:0] exp_be,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_din,
                          input logic exp_mis);
        int stalls;
        int reqs;
        bit done;
        stalls = 0; reqs = 0; done = 1'b0;
        set_in(inst, pc, alu, d2, rd, wr, size, uns, dsel);
        sbq.push_back('{inst, exp_din, exp_mis});
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (obs_req) begin
                reqs++;
                if (reqs == 1) begin
                    chk("dm_addr", obs_addr, exp_addr);
                    chk("dm_be", 64'(obs_be), 64'(exp_be));
                    chk("dm_we", 64'(obs_we), 64'(wr));
                    if (wr) chk("dm_wdata", obs_wdata, exp_wdata);
                end
                if (reqs == waits + 1) begin
                    dm_ack = 1'b1;
                    dm_rdata = rdata;
                end
            end
            if (obs_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                chk("fwd_data", obs_fwd, exp_din);
                if (hold_done) begin
                    hold = 1'b1;
                    repeat (2) begin
                        @(posedge clk);
                        @(negedge clk);
                        chk("hold_req", 64'(obs_req), 64'd0);
                        chk("hold_stall", 64'(obs_stall), 64'd0);
                        chk("hold_inst", 64'(obs_inst), 64'(NOP));
                    end
                    hold = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            dm_ack = 1'b0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: inst %h never advanced", inst);
        end
        chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
        chk("req_cycles", 64'(reqs), 64'(exp_reqs));
    endtask

    task automatic idle();
        set_in(NOP, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, W, 1'b0, ALU);
    endtask

    initial begin
        hold = 1'b0; dm_ack = 1'b0; dm_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst", 64'(obs_inst), 64'(NOP));
        chk("rst_din", obs_din, 64'h0);
        chk("rst_mis", 64'(obs_mis), 64'h0);
        chk("rst_req", 64'(obs_req), 64'h0);
        @(posedge clk); #1; rst = 1'b1;

        // inst pc alu d2 rd wr size uns dsel waits rdata hold | stalls reqs addr be wdata din mis
        run_op(32'h00A00093, 64'h0,   64'h1234_5678, 64'h0, 0, 0, W, 0, ALU,  0, 64'h0, 0,
               0, 0, 64'h0, 8'h0, 64'h0, 64'h1234_5678, 0);
        run_op(32'h008000EF, 64'h100, 64'h0, 64'h0, 0, 0, W, 0, PC4, 0, 64'h0, 0,
               0, 0, 64'h0, 8'h0, 64'h0, 64'h104, 0);
        run_op(32'h00300083, 64'h200, 64'h1003, 64'h0, 1, 0, B, 0, LOAD, 0, 64'h80FF_1234, 0,
               2, 1, 64'h1000, 8'h08, 64'h0, 64'hFFFF_FF80, 0);
        run_op(32'h00304083, 64'h204, 64'h1003, 64'h0, 1, 0, B, 1, LOAD, 0, 64'h80FF_1234, 0,
               2, 1, 64'h1000, 8'h08, 64'h0, 64'h0000_0080, 0);
        run_op(32'h00211123, 64'h208, 64'h2002, 64'h0000_BEEF, 0, 1, H, 0, ALU, 3, 64'h0, 0,
               5, 4, 64'h2000, 8'h0C, 64'hBEEF_0000, 64'h2002, 0);
        run_op(32'h0030A103, 64'h20C, 64'h3001, 64'h0, 1, 0, W, 0, LOAD, 0, 64'h0, 0,
               0, 0, 64'h0, 8'h0, 64'h0, 64'h0, 1);
        run_op(32'h00201183, 64'h210, 64'h1002, 64'h0, 1, 0, H, 0, LOAD, 1, 64'h80FF_1234, 1,
               3, 2, 64'h1000, 8'h0C, 64'h0, 64'hFFFF_80FF, 0);
        run_op(32'h00022203, 64'h214, 64'h4000, 64'h0, 1, 0, W, 0, LOAD, 0, 64'hDEAD_BEEF, 0,
               2, 1, 64'h4000, 8'h0F, 64'h0, 64'hDEAD_BEEF, 0);
        run_op(32'h00000033, 64'h218, 64'h55, 64'h0, 0, 0, W, 0, RSVD, 0, 64'h0, 0,
               0, 0, 64'h0, 8'h0, 64'h0, 64'h0, 0);
        run_op(32'h06400213, 64'h21C, 64'hCAFE, 64'h0, 0, 0, W, 0, ALU, 0, 64'h0, 0,
               0, 0, 64'h0, 8'h0, 64'h0, 64'hCAFE, 0);

        // hold in IDLE freezes WB and blocks launch, then reset mid-access
        hold = 1'b1;
        set_in(32'h00B12023, 64'h220, 64'h5000, 64'h1111_2222, 1'b0, 1'b1, W, 1'b0, ALU);
        repeat (2) begin
            @(negedge clk);
            chk("hold_idle_inst", 64'(obs_inst), 64'h0640_0213);
            chk("hold_idle_din", obs_din, 64'hCAFE);
            chk("hold_idle_req", 64'(obs_req), 64'h0);
            @(posedge clk); #1;
        end
        hold = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("acc_req", 64'(obs_req), 64'h1);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_req", 64'(obs_req), 64'h0);
        chk("midrst_inst", 64'(obs_inst), 64'(NOP));
        chk("midrst_din", obs_din, 64'h0);
        chk("midrst_mis", 64'(obs_mis), 64'h0);
        @(posedge clk); #1; rst = 1'b1;
        run_op(32'h00300283, 64'h300, 64'h1003, 64'h0, 1, 0, B, 0, LOAD, 2, 64'h80FF_1234, 0,
               4, 3, 64'h1000, 8'h08, 64'h0, 64'hFFFF_FF80, 0);

        // switch observation to the 64-bit instance under reset
        idle();
        @(posedge clk); #1; rst = 1'b0; sel64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst64_inst", 64'(obs_inst), 64'(NOP));
        chk("rst64_din", obs_din, 64'h0);
        @(posedge clk); #1; rst = 1'b1;
        run_op(32'h0180B003, 64'h400, 64'h18, 64'h0, 1, 0, D, 0, LOAD, 0, 64'h8000_0000_0000_0001, 0,
               2, 1, 64'h18, 8'hFF, 64'h0, 64'h8000_0000_0000_0001, 0);
        run_op(32'h01C0E083, 64'h404, 64'h1C, 64'h0, 1, 0, W, 1, LOAD, 0, 64'h8000_0000_0000_0001, 0,
               2, 1, 64'h18, 8'hF0, 64'h0, 64'h0000_0000_8000_0000, 0);
        run_op(32'h02B13023, 64'h408, 64'h20, 64'h0123_4567_89AB_CDEF, 0, 1, D, 0, ALU, 1, 64'h0, 0,
               3, 2, 64'h20, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h20, 0);

        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
